// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the clock/calendar core: edit-state codes,
// BCD increment, leap-year and month-length lookup, 12-hour formatting.
package clock_pkg;

  localparam int unsigned BCD_W = 8;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    E_YEAR  = 3'd1,
    E_MONTH = 3'd2,
    E_DAY   = 3'd3,
    E_HOUR  = 3'd4,
    E_MIN   = 3'd5,
    E_SEC   = 3'd6
  } edit_state_e;

  function automatic edit_state_e next_edit_state(input edit_state_e s);
    case (s)
      RUN:     return E_YEAR;
      E_YEAR:  return E_MONTH;
      E_MONTH: return E_DAY;
      E_DAY:   return E_HOUR;
      E_HOUR:  return E_MIN;
      E_MIN:   return E_SEC;
      default: return RUN;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  // Year is 20TU; divisibility by 4 depends only on the parity of T and on U.
  function automatic logic is_leap_bcd(input logic [BCD_W-1:0] year);
    logic [3:0] t;
    logic [3:0] u;
    t = year[7:4];
    u = year[3:0];
    if (t[0]) return (u == 4'd2) || (u == 4'd6);
    else      return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
  endfunction

  function automatic logic [BCD_W-1:0] days_in_month_bcd(input logic [BCD_W-1:0] month,
                                                          input logic leap);
    case (month)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // 24-hour BCD to 12-hour BCD; 20 and 21 need the extra tens borrow.
  function automatic logic [BCD_W-1:0] hour12_bcd(input logic [BCD_W-1:0] h);
    if ((h == 8'h00) || (h == 8'h12)) return 8'h12;
    else if ((h == 8'h20) || (h == 8'h21)) return h - 8'h18;
    else if (h > 8'h12) return h - 8'h12;
    else return h;
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// BCD counter wrapping max->min on inc; a value above a (dynamic) max is
// pulled down to max on the next edge, which implements the day clamp.
module bcd_wrap_counter
  import clock_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc_i,
  input  logic [BCD_W-1:0] init_i,
  input  logic [BCD_W-1:0] min_i,
  input  logic [BCD_W-1:0] max_i,
  output logic [BCD_W-1:0] value_o,
  output logic             wrap_o
);

  logic [BCD_W-1:0] value_q;

  assign value_o = value_q;
  assign wrap_o  = inc_i && (value_q == max_i);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      value_q <= init_i;
    end else if (value_q > max_i) begin
      value_q <= max_i;
    end else if (inc_i) begin
      value_q <= (value_q >= max_i) ? min_i : bcd_inc(value_q);
    end
  end

endmodule

// File: rtl/clock_calendar_core.sv
// BCD time-of-day and calendar with internal 1 Hz divider, field edit FSM,
// 12/24-hour display formatting and hour:minute alarm.
module clock_calendar_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 125000000,
  parameter logic [7:0]  INIT_YEAR  = 8'h00,
  parameter logic [7:0]  INIT_MONTH = 8'h01,
  parameter logic [7:0]  INIT_DAY   = 8'h01
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       set_pulse,
  input  logic       inc_pulse,
  input  logic       mode12,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic [7:0] day_bcd,
  output logic [7:0] mon_bcd,
  output logic [7:0] year_bcd,
  output logic [2:0] edit_field,
  output logic       tick_1hz,
  output logic       alarm_hit
);

  localparam int unsigned     DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

  edit_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             alarm_q, alarm_d;

  logic [7:0] sec_q, min_q, hour_q, day_q, mon_q, year_q;
  logic [7:0] day_max, min_nx, hour_nx;
  logic       sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap, year_wrap_unused;
  logic       edit_inc;
  logic       sec_inc, min_inc, hour_inc, day_inc, mon_inc, year_inc;

  // Divider only runs while the next state is RUN, so edits hold it at zero.
  always_comb begin
    state_d = set_pulse ? next_edit_state(state_q) : state_q;
    div_d   = '0;
    if ((state_d == RUN) && (state_q == RUN) && (div_q != DIV_MAX)) begin
      div_d = div_q + DIV_W'(1);
    end
    tick_d = (state_d == RUN) && (div_d == DIV_MAX);
  end

  // Tick carries ripple only in RUN; edit increments touch a single field.
  always_comb begin
    edit_inc = inc_pulse && !set_pulse;
    sec_inc  = tick_q || (edit_inc && (state_q == E_SEC));
    min_inc  = (tick_q && sec_wrap)  || (edit_inc && (state_q == E_MIN));
    hour_inc = (tick_q && min_wrap)  || (edit_inc && (state_q == E_HOUR));
    day_inc  = (tick_q && hour_wrap) || (edit_inc && (state_q == E_DAY));
    mon_inc  = (tick_q && day_wrap)  || (edit_inc && (state_q == E_MONTH));
    year_inc = (tick_q && mon_wrap)  || (edit_inc && (state_q == E_YEAR));
    day_max  = days_in_month_bcd(mon_q, is_leap_bcd(year_q));
  end

  // Predict the post-tick minute and hour so the alarm lines up with them.
  always_comb begin
    min_nx  = min_wrap ? 8'h00 : bcd_inc(min_q);
    hour_nx = hour_wrap ? 8'h00 : (min_wrap ? bcd_inc(hour_q) : hour_q);
    alarm_d = tick_q && alarm_en && sec_wrap &&
              (min_nx == alarm_mm) && (hour_nx == alarm_hh);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      div_q   <= '0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      alarm_q <= alarm_d;
    end
  end

  bcd_wrap_counter u_sec (
    .CLK(CLK), .RESET(RESET), .inc_i(sec_inc), .init_i(8'h00),
    .min_i(8'h00), .max_i(8'h59), .value_o(sec_q), .wrap_o(sec_wrap)
  );

  bcd_wrap_counter u_min (
    .CLK(CLK), .RESET(RESET), .inc_i(min_inc), .init_i(8'h00),
    .min_i(8'h00), .max_i(8'h59), .value_o(min_q), .wrap_o(min_wrap)
  );

  bcd_wrap_counter u_hour (
    .CLK(CLK), .RESET(RESET), .inc_i(hour_inc), .init_i(8'h00),
    .min_i(8'h00), .max_i(8'h23), .value_o(hour_q), .wrap_o(hour_wrap)
  );

  bcd_wrap_counter u_day (
    .CLK(CLK), .RESET(RESET), .inc_i(day_inc), .init_i(INIT_DAY),
    .min_i(8'h01), .max_i(day_max), .value_o(day_q), .wrap_o(day_wrap)
  );

  bcd_wrap_counter u_mon (
    .CLK(CLK), .RESET(RESET), .inc_i(mon_inc), .init_i(INIT_MONTH),
    .min_i(8'h01), .max_i(8'h12), .value_o(mon_q), .wrap_o(mon_wrap)
  );

  bcd_wrap_counter u_year (
    .CLK(CLK), .RESET(RESET), .inc_i(year_inc), .init_i(INIT_YEAR),
    .min_i(8'h00), .max_i(8'h99), .value_o(year_q), .wrap_o(year_wrap_unused)
  );

  assign sec_bcd    = sec_q;
  assign min_bcd    = min_q;
  assign hour_bcd   = mode12 ? hour12_bcd(hour_q) : hour_q;
  assign pm         = (hour_q >= 8'h12);
  assign day_bcd    = day_q;
  assign mon_bcd    = mon_q;
  assign year_bcd   = year_q;
  assign edit_field = state_q;
  assign tick_1hz   = tick_q;
  assign alarm_hit  = alarm_q;

endmodule

// File: tb/tb_clock_calendar_core.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge
// monitor compares DUT outputs against them.
module tb_clock_calendar_core;

  localparam int unsigned CLK_HZ = 4;

  typedef enum int {K_SEC, K_MIN, K_HOUR, K_DAY, K_MON, K_YEAR,
                    K_FIELD, K_TICK, K_ALARM, K_PM} kind_e;

  typedef struct {
    int         cyc;
    kind_e      kind;
    logic [7:0] want;
    string      name;
  } exp_t;

  exp_t sb[$];

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       set_pulse = 1'b0;
  logic       inc_pulse = 1'b0;
  logic       mode12 = 1'b0;
  logic       alarm_en = 1'b0;
  logic [7:0] alarm_hh = 8'h00;
  logic [7:0] alarm_mm = 8'h00;
  logic [7:0] sec_bcd, min_bcd, hour_bcd, day_bcd, mon_bcd, year_bcd;
  logic       pm, tick_1hz, alarm_hit;
  logic [2:0] edit_field;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int st = 0;

  clock_calendar_core #(
    .CLK_HZ(CLK_HZ), .INIT_YEAR(8'h00), .INIT_MONTH(8'h01), .INIT_DAY(8'h01)
  ) dut (
    .CLK(CLK), .RESET(RESET), .set_pulse(set_pulse), .inc_pulse(inc_pulse),
    .mode12(mode12), .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .pm(pm),
    .day_bcd(day_bcd), .mon_bcd(mon_bcd), .year_bcd(year_bcd),
    .edit_field(edit_field), .tick_1hz(tick_1hz), .alarm_hit(alarm_hit)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] observe(input kind_e k);
    case (k)
      K_SEC:   return sec_bcd;
      K_MIN:   return min_bcd;
      K_HOUR:  return hour_bcd;
      K_DAY:   return day_bcd;
      K_MON:   return mon_bcd;
      K_YEAR:  return year_bcd;
      K_FIELD: return {5'd0, edit_field};
      K_TICK:  return {7'd0, tick_1hz};
      K_ALARM: return {7'd0, alarm_hit};
      default: return {7'd0, pm};
    endcase
  endfunction

  always @(negedge CLK) begin : monitor
    int i;
    logic [7:0] got;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        got = observe(sb[i].kind);
        n_checks++;
        if (got !== sb[i].want) begin
          n_fail++;
          $display("FAIL %s at cycle %0d: got %h, expected %h", sb[i].name, cyc, got, sb[i].want);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d was never sampled", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic expect_at(input int d, input kind_e k, input logic [7:0] v, input string nm);
    sb.push_back('{cyc: cyc + d, kind: k, want: v, name: nm});
  endtask

  function automatic int bin(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    set_pulse = 1'b0;
    inc_pulse = 1'b0;
    run(2);
    RESET = 1'b0;
    st = 0;
  endtask

  task automatic do_set();
    set_pulse = 1'b1;
    step();
    set_pulse = 1'b0;
    st = (st + 1) % 7;
    expect_at(0, K_FIELD, 8'(st), "edit_field");
  endtask

  task automatic do_inc(input int n);
    repeat (n) begin
      inc_pulse = 1'b1;
      step();
    end
    inc_pulse = 1'b0;
  endtask

  task automatic goto_field(input int f);
    while (st != f) do_set();
  endtask

  // Starts from reset values (00/01/01 00:00:00) and leaves the DUT in RUN.
  task automatic set_all(input logic [7:0] y, input logic [7:0] m, input logic [7:0] d,
                         input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    goto_field(1); do_inc(bin(y));
    goto_field(2); do_inc(bin(m) - 1);
    goto_field(3); do_inc(bin(d) - 1);
    goto_field(4); do_inc(bin(h));
    goto_field(5); do_inc(bin(mi));
    goto_field(6); do_inc(bin(s));
    goto_field(0);
  endtask

  initial begin
    // Reset state and first tick
    do_reset();
    expect_at(0, K_SEC, 8'h00, "rst_sec");
    expect_at(0, K_MIN, 8'h00, "rst_min");
    expect_at(0, K_HOUR, 8'h00, "rst_hour");
    expect_at(0, K_DAY, 8'h01, "rst_day");
    expect_at(0, K_MON, 8'h01, "rst_mon");
    expect_at(0, K_YEAR, 8'h00, "rst_year");
    expect_at(0, K_FIELD, 8'h00, "rst_field");
    expect_at(0, K_TICK, 8'h00, "rst_tick");
    expect_at(0, K_ALARM, 8'h00, "rst_alarm");
    expect_at(0, K_PM, 8'h00, "rst_pm");
    expect_at(1, K_TICK, 8'h00, "tick_c2");
    expect_at(2, K_TICK, 8'h00, "tick_c3");
    expect_at(3, K_TICK, 8'h01, "tick_c4");
    expect_at(3, K_SEC, 8'h00, "sec_before_tick");
    expect_at(4, K_TICK, 8'h00, "tick_c5");
    expect_at(4, K_SEC, 8'h01, "sec_after_tick");
    run(5);

    // Full rollover 23:59:59 12/31/99 in 12-hour mode
    mode12 = 1'b1;
    do_reset();
    set_all(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    expect_at(0, K_HOUR, 8'h11, "h12_23");
    expect_at(0, K_PM, 8'h01, "pm_23");
    expect_at(0, K_YEAR, 8'h99, "preset_year");
    expect_at(0, K_DAY, 8'h31, "preset_day");
    expect_at(3, K_TICK, 8'h01, "roll_tick");
    expect_at(4, K_SEC, 8'h00, "roll_sec");
    expect_at(4, K_MIN, 8'h00, "roll_min");
    expect_at(4, K_HOUR, 8'h12, "roll_h12_midnight");
    expect_at(4, K_PM, 8'h00, "roll_pm");
    expect_at(4, K_DAY, 8'h01, "roll_day");
    expect_at(4, K_MON, 8'h01, "roll_mon");
    expect_at(4, K_YEAR, 8'h00, "roll_year");
    run(5);
    mode12 = 1'b0;

    // Feb 28 rollover, leap and non-leap
    do_reset();
    set_all(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    expect_at(4, K_DAY, 8'h29, "leap_day");
    expect_at(4, K_MON, 8'h02, "leap_mon");
    expect_at(4, K_HOUR, 8'h00, "leap_hour");
    run(5);
    do_reset();
    set_all(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    expect_at(4, K_DAY, 8'h01, "nonleap_day");
    expect_at(4, K_MON, 8'h03, "nonleap_mon");
    expect_at(4, K_YEAR, 8'h23, "nonleap_year");
    run(5);

    // Day clamp on month edit: 03/31 -> 04 gives day 30
    do_reset();
    goto_field(2); do_inc(2);
    goto_field(3); do_inc(30);
    expect_at(0, K_DAY, 8'h31, "clamp_pre_day");
    goto_field(0);
    goto_field(2); do_inc(1);
    expect_at(0, K_MON, 8'h04, "clamp_mon");
    expect_at(0, K_DAY, 8'h31, "clamp_day_same_cycle");
    expect_at(1, K_DAY, 8'h30, "clamp_day_30");
    run(2);

    // Day clamp on year edit: 24/02/29 -> year 25 gives day 28
    do_reset();
    goto_field(1); do_inc(24);
    goto_field(2); do_inc(1);
    goto_field(3); do_inc(28);
    expect_at(0, K_DAY, 8'h29, "feb29_set");
    goto_field(0);
    goto_field(1); do_inc(1);
    expect_at(0, K_YEAR, 8'h25, "clamp_year");
    expect_at(1, K_DAY, 8'h28, "clamp_day_28");
    run(2);

    // Set and inc together in E_MIN: set wins
    do_reset();
    goto_field(5);
    set_pulse = 1'b1;
    inc_pulse = 1'b1;
    step();
    set_pulse = 1'b0;
    inc_pulse = 1'b0;
    st = 6;
    expect_at(0, K_FIELD, 8'h06, "set_wins_field");
    expect_at(0, K_MIN, 8'h00, "set_wins_min");
    run(1);

    // Full edit cycle restarts the divider
    do_reset();
    step();
    repeat (7) do_set();
    expect_at(1, K_TICK, 8'h00, "restart_c2");
    expect_at(2, K_TICK, 8'h00, "restart_c3");
    expect_at(3, K_TICK, 8'h01, "restart_tick");
    expect_at(4, K_SEC, 8'h01, "restart_sec");
    run(5);

    // Alarm 07:30 enabled
    alarm_hh = 8'h07;
    alarm_mm = 8'h30;
    alarm_en = 1'b1;
    do_reset();
    set_all(8'h00, 8'h01, 8'h01, 8'h07, 8'h29, 8'h59);
    expect_at(3, K_ALARM, 8'h00, "alarm_before");
    expect_at(4, K_ALARM, 8'h01, "alarm_hit");
    expect_at(4, K_MIN, 8'h30, "alarm_min");
    expect_at(4, K_SEC, 8'h00, "alarm_sec");
    expect_at(5, K_ALARM, 8'h00, "alarm_one_cycle");
    run(6);

    // Alarm disabled
    alarm_en = 1'b0;
    do_reset();
    set_all(8'h00, 8'h01, 8'h01, 8'h07, 8'h29, 8'h59);
    expect_at(4, K_ALARM, 8'h00, "alarm_disabled");
    expect_at(4, K_MIN, 8'h30, "alarm_dis_min");
    run(6);

    // Stepping into the alarm time while editing
    alarm_en = 1'b1;
    do_reset();
    goto_field(4); do_inc(7);
    goto_field(5); do_inc(29);
    do_inc(1);
    expect_at(0, K_MIN, 8'h30, "edit_min_30");
    expect_at(0, K_ALARM, 8'h00, "edit_alarm_c0");
    expect_at(1, K_ALARM, 8'h00, "edit_alarm_c1");
    expect_at(2, K_ALARM, 8'h00, "edit_alarm_c2");
    run(3);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
